// File: rtl/axi_mem_arbiter_pkg.sv
// rtl/axi_mem_arbiter_pkg.sv - shared types and constants for the IFU/LSU memory arbiter
package axi_mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_IFU_RD   = 3'd1,
        ST_LSU_RD   = 3'd2,
        ST_LSU_WR   = 3'd3,
        ST_ERR_RESP = 3'd4
    } state_e;

    // Which master owns the current transaction; kept through ERR_RESP so the
    // fabricated response goes back to the right place.
    typedef enum logic [1:0] {
        GNT_IFU    = 2'd0,
        GNT_LSU_RD = 2'd1,
        GNT_LSU_WR = 2'd2
    } gnt_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_mem_arbiter_watchdog.sv
// rtl/axi_mem_arbiter_watchdog.sv - per-transaction hang detector for the memory arbiter
module axi_watchdog #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] r_count;

    // Cycles spent in the current transaction; restarts on every grant.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CW'(1);
        end
    end

    // A zero limit means the watchdog is switched off entirely.
    assign o_expire = (TIMEOUT != 0) && i_enable && (r_count == CW'(TIMEOUT));

endmodule

// File: rtl/axi_mem_arbiter.sv
// rtl/axi_mem_arbiter.sv - IFU/LSU to single AXI4 slave arbiter, one transaction at a time
module axi_mem_arbiter
    import axi_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_arvalid,
    output logic                ifu_arready,
    input  logic [ADDR_W-1:0]   ifu_araddr,
    input  logic [3:0]          ifu_arid,
    input  logic [7:0]          ifu_arlen,
    input  logic [2:0]          ifu_arsize,
    input  logic [1:0]          ifu_arburst,
    output logic                ifu_rvalid,
    input  logic                ifu_rready,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic [1:0]          ifu_rresp,
    output logic                ifu_rlast,
    output logic [3:0]          ifu_rid,
    input  logic                lsu_arvalid,
    output logic                lsu_arready,
    input  logic [ADDR_W-1:0]   lsu_araddr,
    input  logic [3:0]          lsu_arid,
    input  logic [7:0]          lsu_arlen,
    input  logic [2:0]          lsu_arsize,
    input  logic [1:0]          lsu_arburst,
    output logic                lsu_rvalid,
    input  logic                lsu_rready,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic [1:0]          lsu_rresp,
    output logic                lsu_rlast,
    output logic [3:0]          lsu_rid,
    input  logic                lsu_awvalid,
    output logic                lsu_awready,
    input  logic [ADDR_W-1:0]   lsu_awaddr,
    input  logic [3:0]          lsu_awid,
    input  logic [7:0]          lsu_awlen,
    input  logic [2:0]          lsu_awsize,
    input  logic [1:0]          lsu_awburst,
    input  logic                lsu_wvalid,
    output logic                lsu_wready,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    input  logic                lsu_wlast,
    output logic                lsu_bvalid,
    input  logic                lsu_bready,
    output logic [1:0]          lsu_bresp,
    output logic [3:0]          lsu_bid,
    output logic                m_arvalid,
    input  logic                m_arready,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [3:0]          m_arid,
    output logic [7:0]          m_arlen,
    output logic [2:0]          m_arsize,
    output logic [1:0]          m_arburst,
    input  logic                m_rvalid,
    output logic                m_rready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rlast,
    input  logic [3:0]          m_rid,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [3:0]          m_awid,
    output logic [7:0]          m_awlen,
    output logic [2:0]          m_awsize,
    output logic [1:0]          m_awburst,
    output logic                m_wvalid,
    input  logic                m_wready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,
    input  logic                m_bvalid,
    output logic                m_bready,
    input  logic [1:0]          m_bresp,
    input  logic [3:0]          m_bid,
    output logic                timeout_err
);

    state_e     r_state;
    gnt_e       r_gnt;
    logic [3:0] r_err_id;

    logic w_busy;
    logic w_grant;
    logic w_rd_done;
    logic w_wr_done;
    logic w_expire;
    logic w_err_ack;

    assign w_busy    = (r_state == ST_IFU_RD) || (r_state == ST_LSU_RD) || (r_state == ST_LSU_WR);
    assign w_grant   = (r_state == ST_IDLE) && (lsu_awvalid || lsu_arvalid || ifu_arvalid);
    assign w_rd_done = ((r_state == ST_IFU_RD) || (r_state == ST_LSU_RD)) && m_rvalid && m_rready && m_rlast;
    assign w_wr_done = (r_state == ST_LSU_WR) && m_bvalid && m_bready;
    assign w_err_ack = (r_gnt == GNT_IFU)    ? ifu_rready :
                       (r_gnt == GNT_LSU_RD) ? lsu_rready : lsu_bready;

    // A slave that finishes on the very cycle the limit is hit wins over the timeout.
    assign timeout_err = w_expire && !w_rd_done && !w_wr_done;

    axi_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_grant),
        .i_enable (w_busy),
        .o_expire (w_expire)
    );

    // Grant/transaction state; the id is latched so an error reply carries the request's id.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_gnt    <= GNT_IFU;
            r_err_id <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (lsu_awvalid) begin
                        r_state  <= ST_LSU_WR;
                        r_gnt    <= GNT_LSU_WR;
                        r_err_id <= lsu_awid;
                    end else if (lsu_arvalid) begin
                        r_state  <= ST_LSU_RD;
                        r_gnt    <= GNT_LSU_RD;
                        r_err_id <= lsu_arid;
                    end else if (ifu_arvalid) begin
                        r_state  <= ST_IFU_RD;
                        r_gnt    <= GNT_IFU;
                        r_err_id <= ifu_arid;
                    end
                end
                ST_IFU_RD, ST_LSU_RD, ST_LSU_WR: begin
                    if (w_rd_done || w_wr_done) begin
                        r_state <= ST_IDLE;
                    end else if (w_expire) begin
                        r_state <= ST_ERR_RESP;
                    end
                end
                ST_ERR_RESP: begin
                    if (w_err_ack) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Request payloads need no gating: the slave only looks at them under a valid.
    assign m_araddr  = (r_gnt == GNT_LSU_RD) ? lsu_araddr  : ifu_araddr;
    assign m_arid    = (r_gnt == GNT_LSU_RD) ? lsu_arid    : ifu_arid;
    assign m_arlen   = (r_gnt == GNT_LSU_RD) ? lsu_arlen   : ifu_arlen;
    assign m_arsize  = (r_gnt == GNT_LSU_RD) ? lsu_arsize  : ifu_arsize;
    assign m_arburst = (r_gnt == GNT_LSU_RD) ? lsu_arburst : ifu_arburst;
    assign m_awaddr  = lsu_awaddr;
    assign m_awid    = lsu_awid;
    assign m_awlen   = lsu_awlen;
    assign m_awsize  = lsu_awsize;
    assign m_awburst = lsu_awburst;
    assign m_wdata   = lsu_wdata;
    assign m_wstrb   = lsu_wstrb;
    assign m_wlast   = lsu_wlast;

    // Handshake routing to the granted master, plus the fabricated error reply.
    always_comb begin
        m_arvalid   = 1'b0;
        m_rready    = 1'b0;
        m_awvalid   = 1'b0;
        m_wvalid    = 1'b0;
        m_bready    = 1'b0;
        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bvalid  = 1'b0;
        ifu_rdata   = m_rdata;
        ifu_rresp   = m_rresp;
        ifu_rlast   = m_rlast;
        ifu_rid     = m_rid;
        lsu_rdata   = m_rdata;
        lsu_rresp   = m_rresp;
        lsu_rlast   = m_rlast;
        lsu_rid     = m_rid;
        lsu_bresp   = m_bresp;
        lsu_bid     = m_bid;
        case (r_state)
            ST_IFU_RD: begin
                m_arvalid   = ifu_arvalid;
                ifu_arready = m_arready;
                ifu_rvalid  = m_rvalid;
                m_rready    = ifu_rready;
            end
            ST_LSU_RD: begin
                m_arvalid   = lsu_arvalid;
                lsu_arready = m_arready;
                lsu_rvalid  = m_rvalid;
                m_rready    = lsu_rready;
            end
            ST_LSU_WR: begin
                m_awvalid   = lsu_awvalid;
                lsu_awready = m_awready;
                m_wvalid    = lsu_wvalid;
                lsu_wready  = m_wready;
                lsu_bvalid  = m_bvalid;
                m_bready    = lsu_bready;
            end
            ST_ERR_RESP: begin
                case (r_gnt)
                    GNT_IFU: begin
                        ifu_rvalid = 1'b1;
                        ifu_rdata  = '0;
                        ifu_rresp  = RESP_SLVERR;
                        ifu_rlast  = 1'b1;
                        ifu_rid    = r_err_id;
                    end
                    GNT_LSU_RD: begin
                        lsu_rvalid = 1'b1;
                        lsu_rdata  = '0;
                        lsu_rresp  = RESP_SLVERR;
                        lsu_rlast  = 1'b1;
                        lsu_rid    = r_err_id;
                    end
                    default: begin
                        lsu_bvalid = 1'b1;
                        lsu_bresp  = RESP_SLVERR;
                        lsu_bid    = r_err_id;
                    end
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// tb/tb_axi_mem_arbiter.sv - self-checking bench for the IFU/LSU memory arbiter
module tb_axi_mem_arbiter;
    import axi_mem_arbiter_pkg::*;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ifu_arvalid = 0, ifu_arready, ifu_rvalid, ifu_rready = 0, ifu_rlast;
    logic [31:0] ifu_araddr = 0, ifu_rdata;
    logic [3:0] ifu_arid = 4'h1, ifu_rid;
    logic [7:0] ifu_arlen = 0;
    logic [2:0] ifu_arsize = 3'd2;
    logic [1:0] ifu_arburst = 2'b01, ifu_rresp;
    logic lsu_arvalid = 0, lsu_arready, lsu_rvalid, lsu_rready = 0, lsu_rlast;
    logic [31:0] lsu_araddr = 0, lsu_rdata;
    logic [3:0] lsu_arid = 4'h2, lsu_rid;
    logic [7:0] lsu_arlen = 0;
    logic [2:0] lsu_arsize = 3'd2;
    logic [1:0] lsu_arburst = 2'b01, lsu_rresp;
    logic lsu_awvalid = 0, lsu_awready, lsu_wvalid = 0, lsu_wready, lsu_wlast = 0;
    logic [31:0] lsu_awaddr = 0, lsu_wdata = 0;
    logic [3:0] lsu_awid = 4'h3, lsu_bid, lsu_wstrb = 0;
    logic [7:0] lsu_awlen = 0;
    logic [2:0] lsu_awsize = 3'd2;
    logic [1:0] lsu_awburst = 2'b01, lsu_bresp;
    logic lsu_bvalid, lsu_bready = 0;
    logic m_arvalid, m_arready = 0, m_rvalid = 0, m_rready, m_rlast = 0;
    logic [31:0] m_araddr, m_rdata = 0;
    logic [3:0] m_arid, m_rid = 0;
    logic [7:0] m_arlen;
    logic [2:0] m_arsize;
    logic [1:0] m_arburst, m_rresp = 0;
    logic m_awvalid, m_awready = 0, m_wvalid, m_wready = 0, m_wlast;
    logic [31:0] m_awaddr, m_wdata;
    logic [3:0] m_awid, m_wstrb, m_bid = 0;
    logic [7:0] m_awlen;
    logic [2:0] m_awsize;
    logic [1:0] m_awburst, m_bresp = 0;
    logic m_bvalid = 0, m_bready;
    logic timeout_err;

    int n_checks = 0;
    int n_fail = 0;
    bit mon_on = 0;
    int owner = 0;   // 0 none, 1 ifu rd, 2 lsu rd, 3 lsu wr, 4/5/6 error reply to 1/2/3
    int age = 0;

    always #5 clk = ~clk;

    axi_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
        .ifu_arid(ifu_arid), .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize), .ifu_arburst(ifu_arburst),
        .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata),
        .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast), .ifu_rid(ifu_rid),
        .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
        .lsu_arid(lsu_arid), .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize), .lsu_arburst(lsu_arburst),
        .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata),
        .lsu_rresp(lsu_rresp), .lsu_rlast(lsu_rlast), .lsu_rid(lsu_rid),
        .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready), .lsu_awaddr(lsu_awaddr),
        .lsu_awid(lsu_awid), .lsu_awlen(lsu_awlen), .lsu_awsize(lsu_awsize), .lsu_awburst(lsu_awburst),
        .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready), .lsu_wdata(lsu_wdata),
        .lsu_wstrb(lsu_wstrb), .lsu_wlast(lsu_wlast),
        .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready), .lsu_bresp(lsu_bresp), .lsu_bid(lsu_bid),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast), .m_rid(m_rid),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
        .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp), .m_bid(m_bid),
        .timeout_err(timeout_err)
    );

    wire [12:0] act_v = {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, ifu_arready, ifu_rvalid,
                         lsu_arready, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid, timeout_err};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: who owns the slave port, and how long they have held it.
    always @(negedge clk) begin : monitor
        bit ea, er, eaw, ew, eb, eia, eir, ela, elr, elaw, elw, elb, et, done;
        if (mon_on) begin
            {ea, er, eaw, ew, eb, eia, eir, ela, elr, elaw, elw, elb, et} = '0;
            if (owner == 1) begin ea = ifu_arvalid; er = ifu_rready; eia = m_arready; eir = m_rvalid; end
            if (owner == 2) begin ea = lsu_arvalid; er = lsu_rready; ela = m_arready; elr = m_rvalid; end
            if (owner == 3) begin
                eaw = lsu_awvalid; ew = lsu_wvalid; eb = lsu_bready;
                elaw = m_awready; elw = m_wready; elb = m_bvalid;
            end
            if (owner == 4) eir = 1'b1;
            if (owner == 5) elr = 1'b1;
            if (owner == 6) elb = 1'b1;
            done = (owner == 1 || owner == 2) ? (m_rvalid && er && m_rlast) :
                   (owner == 3) ? (m_bvalid && eb) : 1'b0;
            et = (owner >= 1 && owner <= 3) && (age == TO) && !done;
            check("handshakes", act_v, {ea, er, eaw, ew, eb, eia, eir, ela, elr, elaw, elw, elb, et});
            if (ea) check("m_araddr", m_araddr, (owner == 1) ? ifu_araddr : lsu_araddr);
            if (eaw) check("m_awaddr", m_awaddr, lsu_awaddr);
            if (ew) check("m_wdata", {m_wstrb, m_wdata}, {lsu_wstrb, lsu_wdata});
            if (eir) check("ifu_r", {ifu_rdata, ifu_rresp, ifu_rlast},
                           (owner == 4) ? {32'h0, 2'b10, 1'b1} : {m_rdata, m_rresp, m_rlast});
            if (elr) check("lsu_r", {lsu_rdata, lsu_rresp, lsu_rlast},
                           (owner == 5) ? {32'h0, 2'b10, 1'b1} : {m_rdata, m_rresp, m_rlast});
            if (elb) check("lsu_bresp", lsu_bresp, (owner == 6) ? 2'b10 : m_bresp);
            if (rst) begin
                owner = 0; age = 0;
            end else if (owner == 0) begin
                age = 0;
                if (lsu_awvalid) owner = 3;
                else if (lsu_arvalid) owner = 2;
                else if (ifu_arvalid) owner = 1;
            end else if (owner <= 3) begin
                if (done) owner = 0;
                else if (age == TO) owner = owner + 3;
                else age++;
            end else if ((owner == 4 && ifu_rready) || (owner == 5 && lsu_rready) || (owner == 6 && lsu_bready)) begin
                owner = 0;
            end
        end
    end

    // Slave side of one read: accept AR, wait, return beats; reports what the masters saw.
    task automatic rd_slave(input int lat, input int beats, input logic [31:0] d0,
                            output int ar_wait, output logic [31:0] ar_addr, output int nb,
                            output int who, output logic [31:0] rd, output logic [1:0] rr);
        int t;
        bit gi, gl;
        t = 0; nb = 0; who = 0; rd = '0; rr = '0;
        while (!m_arvalid && t < 20) begin tick(); t++; end
        ar_wait = t;
        ar_addr = m_araddr;
        if (t >= 20) begin
            check("ar_wait_bound", t, 0);
            return;
        end
        m_arready = 1;
        @(negedge clk);
        gi = ifu_arready;
        gl = lsu_arready;
        tick();
        m_arready = 0;
        if (gi) ifu_arvalid = 0;
        if (gl) lsu_arvalid = 0;
        for (int i = 1; i < lat; i++) tick();
        for (int i = 0; i < beats; i++) begin
            m_rvalid = 1; m_rdata = d0 + i; m_rresp = 2'b00; m_rlast = (i == beats - 1);
            @(negedge clk);
            if (ifu_rvalid) begin nb++; who = 1; rd = ifu_rdata; rr = ifu_rresp; end
            else if (lsu_rvalid) begin nb++; who = 2; rd = lsu_rdata; rr = lsu_rresp; end
            tick();
        end
        m_rvalid = 0; m_rlast = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int aw, nb, who, c;
        logic [31:0] addr, rd;
        logic [1:0] rr;
        bit fired;

        ifu_rready = 1; lsu_rready = 1; lsu_bready = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        mon_on = 1;
        @(negedge clk);
        check("reset_outputs", act_v, 13'h0);
        check("reset_state", dut.r_state, ST_IDLE);
        check("reset_wd_count", dut.u_wd.r_count, 0);
        tick();

        // IFU single read, slave latency 3
        ifu_arvalid = 1; ifu_araddr = 32'h8000_0000;
        rd_slave(3, 1, 32'h0000_0413, aw, addr, nb, who, rd, rr);
        check("s1_ar_latency", aw, 1);
        check("s1_araddr", addr, 32'h8000_0000);
        check("s1_rdata", rd, 32'h0000_0413);
        check("s1_rresp", rr, 2'b00);
        check("s1_who", who, 1);
        @(negedge clk);
        check("s1_idle", dut.r_state, ST_IDLE);
        tick();

        // Read contention: LSU first, IFU afterwards
        ifu_arvalid = 1; ifu_araddr = 32'h8000_0100;
        lsu_arvalid = 1; lsu_araddr = 32'h8000_1000;
        rd_slave(2, 1, 32'h1111_1111, aw, addr, nb, who, rd, rr);
        check("s2_first_addr", addr, 32'h8000_1000);
        check("s2_first_who", who, 2);
        rd_slave(1, 1, 32'h2222_2222, aw, addr, nb, who, rd, rr);
        check("s2_second_addr", addr, 32'h8000_0100);
        check("s2_second_who", who, 1);
        tick();

        // LSU write with W presented before AW; IFU request pending meanwhile
        lsu_wvalid = 1; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF; lsu_wlast = 1;
        tick();
        lsu_awvalid = 1; lsu_awaddr = 32'h8000_2000;
        ifu_arvalid = 1; ifu_araddr = 32'h8000_0200;
        tick();
        m_wready = 1;
        @(negedge clk);
        check("s3_wvalid", m_wvalid, 1'b1);
        check("s3_wdata", m_wdata, 32'hDEAD_BEEF);
        check("s3_wstrb", m_wstrb, 4'hF);
        tick();
        lsu_wvalid = 0; lsu_wlast = 0; m_wready = 0; m_awready = 1;
        @(negedge clk);
        check("s3_awaddr", {m_awvalid, m_awaddr}, {1'b1, 32'h8000_2000});
        tick();
        lsu_awvalid = 0; m_awready = 0;
        tick();
        m_bvalid = 1; m_bresp = 2'b00;
        @(negedge clk);
        check("s3_bvalid_bresp", {lsu_bvalid, lsu_bresp}, {1'b1, 2'b00});
        check("s3_ifu_held", ifu_arready, 1'b0);
        tick();
        m_bvalid = 0;
        rd_slave(1, 1, 32'h3333_3333, aw, addr, nb, who, rd, rr);
        check("s3_ifu_after_addr", addr, 32'h8000_0200);
        check("s3_ifu_after_who", who, 1);
        tick();

        // Burst read, arlen=3
        lsu_arvalid = 1; lsu_araddr = 32'h8000_3000; lsu_arlen = 8'd3;
        rd_slave(1, 4, 32'h0000_0100, aw, addr, nb, who, rd, rr);
        check("s4_beats", nb, 4);
        check("s4_last_data", rd, 32'h0000_0103);
        @(negedge clk);
        check("s4_idle", dut.r_state, ST_IDLE);
        lsu_arlen = 8'd0;
        tick();

        // Watchdog: slave never answers an IFU read
        ifu_arvalid = 1; ifu_araddr = 32'h8000_4000;
        tick();
        c = 0; fired = 0;
        while (c < 30 && !fired) begin
            @(negedge clk);
            if (timeout_err) fired = 1;
            else begin tick(); c++; end
        end
        check("s5_fired", fired, 1'b1);
        check("s5_fire_cycle", c, 8);
        tick();
        ifu_arvalid = 0; ifu_rready = 0;
        @(negedge clk);
        check("s5_err_resp", {ifu_rvalid, ifu_rresp, ifu_rlast, ifu_rdata}, {1'b1, 2'b10, 1'b1, 32'h0});
        check("s5_m_quiet", {m_arvalid, m_rready}, 2'b00);
        tick();
        @(negedge clk);
        check("s5_err_held", ifu_rvalid, 1'b1);
        tick();
        ifu_rready = 1;
        tick();
        m_rvalid = 1; m_rlast = 1; m_rdata = 32'h0000_0BAD;
        @(negedge clk);
        check("s5_stray_dropped", {ifu_rvalid, m_rready}, 2'b00);
        tick();
        m_rvalid = 0; m_rlast = 0;
        tick();

        // Reset while a write is in flight
        lsu_awvalid = 1; lsu_awaddr = 32'h8000_5000; lsu_wvalid = 1; lsu_wdata = 32'h5555_5555;
        tick();
        @(negedge clk);
        check("s6_in_write", dut.r_state, ST_LSU_WR);
        tick();
        rst = 1; lsu_awvalid = 0; lsu_wvalid = 0;
        tick();
        rst = 0;
        @(negedge clk);
        check("s6_outputs_zero", act_v, 13'h0);
        check("s6_idle", dut.r_state, ST_IDLE);
        tick();
        ifu_arvalid = 1; ifu_araddr = 32'h8000_6000;
        rd_slave(2, 1, 32'h6666_6666, aw, addr, nb, who, rd, rr);
        check("s6_fresh_read", {who, rd, rr}, {32'd1, 32'h6666_6666, 2'b00});

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
